// File: rtl/alu_issue_queue_pkg.sv
// Shared micro-op types for the ALU issue path: opcode and immediate-kind
// enums plus the issue-queue entry layout and wakeup helpers.
package uopc;
   typedef enum logic [4:0] {
      UOP_NOP, UOP_ADD, UOP_SUB, UOP_AND, UOP_OR, UOP_XOR, UOP_SLL, UOP_SRL,
      UOP_SRA, UOP_SLT, UOP_SLTU, UOP_ADDI, UOP_ANDI, UOP_ORI, UOP_XORI,
      UOP_SLTI, UOP_SLTIU, UOP_SLLI, UOP_SRLI, UOP_SRAI, UOP_LUI, UOP_AUIPC
   } micro_opcode_t;
endpackage

package immt;
   typedef enum logic [2:0] {
      IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
   } imm_type_t;
endpackage

package rv32i_types;
   localparam int PKG_PREG_W   = 6;
   localparam int PKG_ROB_W    = 5;
   localparam int NUM_WB_PORTS = 2;

   typedef logic [PKG_PREG_W-1:0] preg_t;

   typedef struct packed {
      uopc::micro_opcode_t   uopcode;
      logic [19:0]           packed_imm;
      immt::imm_type_t       imm_type;
      preg_t                 prs1;
      preg_t                 prs2;
      logic                  prs1_busy;
      logic                  prs2_busy;
      preg_t                 pdst;
      logic [PKG_ROB_W-1:0]  rob_idx;
   } iq_entry_t;

   // True when any valid wakeup port broadcasts this tag.
   function automatic logic tag_hit(
      input preg_t                                   tag,
      input logic [NUM_WB_PORTS-1:0]                 v,
      input logic [NUM_WB_PORTS-1:0][PKG_PREG_W-1:0] t
   );
      logic hit;
      hit = 1'b0;
      for (int p = 0; p < NUM_WB_PORTS; p++) begin
         if (v[p] && (t[p] == tag)) hit = 1'b1;
      end
      return hit;
   endfunction

   // Clears the busy bit of each source whose producer is broadcasting.
   function automatic iq_entry_t wake_entry(
      input iq_entry_t                               e,
      input logic [NUM_WB_PORTS-1:0]                 v,
      input logic [NUM_WB_PORTS-1:0][PKG_PREG_W-1:0] t
   );
      iq_entry_t r;
      r = e;
      if (tag_hit(e.prs1, v, t)) r.prs1_busy = 1'b0;
      if (tag_hit(e.prs2, v, t)) r.prs2_busy = 1'b0;
      return r;
   endfunction
endpackage

// File: rtl/alu_issue_queue_select.sv
// Fixed-priority picker: lowest-index request wins, reported both as a
// one-hot grant and as a binary index.
module iq_select #(
   parameter int N     = 8,
   parameter int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   // Scan from the top down so the lowest set bit is the last one written.
   always_comb begin
      grant = '0;
      idx   = '0;
      any   = |req;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            grant    = '0;
            grant[i] = 1'b1;
            idx      = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/alu_issue_queue.sv
// Collapsing ALU issue queue. Entries live contiguously at 0..count-1 with
// index 0 oldest; wakeups clear busy bits, the oldest ready entry is offered,
// and an issued slot is closed by shifting younger entries down one place.
//
// Handshakes: a dispatch transfers on a cycle where disp_valid && disp_ready;
// an issue transfers on a cycle where issue_valid && issue_ready. Both ready
// and valid outputs are derived only from registered state plus rst/flush,
// never from the partner's valid/ready.
module alu_issue_queue
   import rv32i_types::*;
#(
   parameter int  DEPTH  = 8,
   parameter int  PREG_W = PKG_PREG_W,
   parameter int  ROB_W  = PKG_ROB_W,
   localparam int CNT_W  = $clog2(DEPTH + 1),
   localparam int IDX_W  = $clog2(DEPTH)
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                flush,
   input  logic                                disp_valid,
   output logic                                disp_ready,
   input  iq_entry_t                           disp_uop,
   input  logic [NUM_WB_PORTS-1:0]             wb_valid,
   input  logic [NUM_WB_PORTS-1:0][PREG_W-1:0] wb_ptag,
   output logic                                issue_valid,
   input  logic                                issue_ready,
   output iq_entry_t                           issue_uop,
   output logic [CNT_W-1:0]                    count
);

   iq_entry_t        entries_q [DEPTH];
   iq_entry_t        entries_d [DEPTH];
   logic [DEPTH-1:0] valid_q, valid_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [CNT_W-1:0] wr_idx;
   logic [DEPTH-1:0] ready_vec;
   logic [DEPTH-1:0] sel_grant;
   logic [DEPTH-1:0] shift_mask;
   logic [IDX_W-1:0] sel_idx;
   logic             sel_any;
   logic             disp_fire;
   logic             issue_fire;
   iq_entry_t        disp_entry;

   // An entry can issue once it is occupied and neither source is pending.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         ready_vec[i] = valid_q[i] && !entries_q[i].prs1_busy && !entries_q[i].prs2_busy;
      end
   end

   iq_select #(
      .N     (DEPTH),
      .IDX_W (IDX_W)
   ) u_select (
      .req   (ready_vec),
      .grant (sel_grant),
      .idx   (sel_idx),
      .any   (sel_any)
   );

   // Handshake outputs and the presented uop (busy bits are zero by construction).
   always_comb begin
      disp_ready  = !rst && !flush && (count_q < CNT_W'(DEPTH));
      issue_valid = sel_any && !rst && !flush;
      disp_fire   = disp_valid && disp_ready;
      issue_fire  = issue_valid && issue_ready;
      issue_uop           = entries_q[sel_idx];
      issue_uop.prs1_busy = 1'b0;
      issue_uop.prs2_busy = 1'b0;
      issue_uop.rob_idx   = ROB_W'(entries_q[sel_idx].rob_idx);
   end

   // Incoming uop: same-cycle wakeups bypass into the busy bits, x0 is never busy.
   always_comb begin
      disp_entry           = disp_uop;
      disp_entry.prs1_busy = disp_uop.prs1_busy && (disp_uop.prs1 != '0)
                             && !tag_hit(disp_uop.prs1, wb_valid, wb_ptag);
      disp_entry.prs2_busy = disp_uop.prs2_busy && (disp_uop.prs2 != '0)
                             && !tag_hit(disp_uop.prs2, wb_valid, wb_ptag);
   end

   // Slots at or above the issued one take their younger neighbour.
   always_comb begin
      logic acc;
      acc = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         acc           = acc | sel_grant[i];
         shift_mask[i] = acc && issue_fire;
      end
   end

   // Next queue contents: collapse, wake, append, then count and flush.
   always_comb begin
      int src;
      src       = 0;
      entries_d = entries_q;
      valid_d   = valid_q;
      count_d   = count_q;
      wr_idx    = issue_fire ? (count_q - CNT_W'(1)) : count_q;
      for (int i = 0; i < DEPTH; i++) begin
         src = (i < DEPTH - 1) ? (i + 1) : i;
         if (shift_mask[i]) begin
            entries_d[i] = wake_entry(entries_q[src], wb_valid, wb_ptag);
            valid_d[i]   = (i < DEPTH - 1) ? valid_q[src] : 1'b0;
         end else begin
            entries_d[i] = wake_entry(entries_q[i], wb_valid, wb_ptag);
         end
         if (disp_fire && (i == int'(wr_idx))) begin
            entries_d[i] = disp_entry;
            valid_d[i]   = 1'b1;
         end
      end
      case ({disp_fire, issue_fire})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
      if (flush) begin
         valid_d = '0;
         count_d = '0;
      end
   end

   // Occupancy state with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         count_q <= '0;
      end else begin
         valid_q <= valid_d;
         count_q <= count_d;
      end
   end

   // Payload storage; meaningless while its valid bit is clear, so no reset.
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         entries_q[i] <= entries_d[i];
      end
   end

   assign count = count_q;

endmodule

// File: tb/tb_alu_issue_queue.sv
// Bench for alu_issue_queue: directed scenarios plus a randomized run, all
// checked against a queue-based model of the issue queue.
module tb_alu_issue_queue;
  import rv32i_types::*;

  logic            clk, rst, flush, disp_valid, disp_ready;
  logic            issue_valid, issue_ready;
  iq_entry_t       disp_uop, issue_uop;
  logic [1:0]      wb_valid;
  logic [1:0][5:0] wb_ptag;
  logic [3:0]      count;

  iq_entry_t mq[$];   // model: oldest at index 0
  int total = 0;
  int bad   = 0;

  alu_issue_queue #(.DEPTH(8), .PREG_W(6), .ROB_W(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_uop(disp_uop),
    .wb_valid(wb_valid), .wb_ptag(wb_ptag),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_uop(issue_uop),
    .count(count)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  function automatic iq_entry_t mk(uopc::micro_opcode_t op, logic [5:0] r1, logic b1,
                                   logic [5:0] r2, logic b2, logic [4:0] rob);
    iq_entry_t u;
    u.uopcode    = op;
    u.packed_imm = 20'h5a000 | 20'(rob);
    u.imm_type   = immt::IMM_I;
    u.prs1       = r1;
    u.prs1_busy  = b1;
    u.prs2       = r2;
    u.prs2_busy  = b2;
    u.pdst       = {1'b1, rob};
    u.rob_idx    = rob;
    return u;
  endfunction

  function automatic int model_sel();
    for (int i = 0; i < mq.size(); i++)
      if (!mq[i].prs1_busy && !mq[i].prs2_busy) return i;
    return -1;
  endfunction

  function automatic bit model_hit(logic [5:0] tag);
    for (int p = 0; p < 2; p++)
      if (wb_valid[p] && wb_ptag[p] == tag) return 1'b1;
    return 1'b0;
  endfunction

  // Advance one clock with the currently driven inputs, updating the model.
  task automatic tick();
    int k;
    bit ifire, dfire;
    iq_entry_t n;
    iq_entry_t nq[$];
    k     = model_sel();
    ifire = !rst && !flush && issue_ready && (k >= 0);
    dfire = !rst && !flush && disp_valid && (mq.size() < 8);
    nq    = mq;
    if (ifire) nq.delete(k);
    for (int i = 0; i < nq.size(); i++) begin
      if (model_hit(nq[i].prs1)) nq[i].prs1_busy = 1'b0;
      if (model_hit(nq[i].prs2)) nq[i].prs2_busy = 1'b0;
    end
    if (dfire) begin
      n = disp_uop;
      if (n.prs1 == 6'd0 || model_hit(n.prs1)) n.prs1_busy = 1'b0;
      if (n.prs2 == 6'd0 || model_hit(n.prs2)) n.prs2_busy = 1'b0;
      nq.push_back(n);
    end
    if (rst || flush) nq.delete();
    @(posedge clk);
    #1;
    mq = nq;
    disp_valid = 1'b0; issue_ready = 1'b0; wb_valid = 2'b00; flush = 1'b0;
    #1;
  endtask

  task automatic dispatch(iq_entry_t u);
    disp_valid = 1'b1;
    disp_uop   = u;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; disp_valid = 1'b0; issue_ready = 1'b0;
    wb_valid = 2'b00; wb_ptag = '0; disp_uop = mk(uopc::UOP_NOP, 0, 0, 0, 0, 0);
    #1;
    total++; if (disp_ready !== 1'b0) begin bad++; $display("FAIL reset_disp_ready: got %0b expected 0", disp_ready); end
    total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL reset_issue_valid: got %0b expected 0", issue_valid); end
    tick(); tick();
    rst = 1'b0; #1;
    total++; if (count !== 4'd0) begin bad++; $display("FAIL reset_count: got %0d expected 0", count); end
    total++; if (disp_ready !== 1'b1) begin bad++; $display("FAIL post_reset_disp_ready: got %0b expected 1", disp_ready); end
    total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL post_reset_issue_valid: got %0b expected 0", issue_valid); end
  endtask

  task automatic test_basic_addi();
    dispatch(mk(uopc::UOP_ADDI, 6'd1, 1'b0, 6'd2, 1'b0, 5'd1));
    total++; if (issue_valid !== 1'b1) begin bad++; $display("FAIL addi_issue_valid: got %0b expected 1", issue_valid); end
    total++; if (issue_uop.uopcode !== uopc::UOP_ADDI) begin bad++; $display("FAIL addi_uopcode: got %0d expected %0d", issue_uop.uopcode, uopc::UOP_ADDI); end
    total++; if (issue_uop !== mk(uopc::UOP_ADDI, 6'd1, 1'b0, 6'd2, 1'b0, 5'd1)) begin bad++; $display("FAIL addi_payload: got %h expected %h", issue_uop, mk(uopc::UOP_ADDI, 6'd1, 1'b0, 6'd2, 1'b0, 5'd1)); end
    total++; if (count !== 4'd1) begin bad++; $display("FAIL addi_count1: got %0d expected 1", count); end
    issue_ready = 1'b1; tick();
    total++; if (count !== 4'd0) begin bad++; $display("FAIL addi_count0: got %0d expected 0", count); end
    total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL addi_drained: got %0b expected 0", issue_valid); end
  endtask

  task automatic test_wakeup_order();
    dispatch(mk(uopc::UOP_ADD, 6'd5, 1'b1, 6'd6, 1'b0, 5'd2));
    dispatch(mk(uopc::UOP_SUB, 6'd7, 1'b0, 6'd8, 1'b0, 5'd3));
    total++; if (issue_uop.uopcode !== uopc::UOP_SUB || issue_valid !== 1'b1) begin bad++; $display("FAIL order_sub_first: got %0d expected %0d", issue_uop.uopcode, uopc::UOP_SUB); end
    issue_ready = 1'b1; wb_valid = 2'b01; wb_ptag[0] = 6'd5; #1;
    tick();
    total++; if (issue_valid !== 1'b1 || issue_uop.uopcode !== uopc::UOP_ADD) begin bad++; $display("FAIL order_add_next: got %0d expected %0d", issue_uop.uopcode, uopc::UOP_ADD); end
    total++; if (issue_uop.prs1_busy !== 1'b0) begin bad++; $display("FAIL order_add_busy: got %0b expected 0", issue_uop.prs1_busy); end
    total++; if (count !== 4'd1) begin bad++; $display("FAIL order_count: got %0d expected 1", count); end
    issue_ready = 1'b1; tick();
    total++; if (count !== 4'd0) begin bad++; $display("FAIL order_drain: got %0d expected 0", count); end
  endtask

  task automatic test_full();
    int exp_rob[7] = '{0, 1, 2, 4, 5, 6, 7};
    int tags[8]    = '{10, 11, 12, 14, 15, 16, 17, 0};
    for (int i = 0; i < 8; i++) dispatch(mk(uopc::UOP_ADD, 6'(10 + i), 1'b1, 6'd0, 1'b0, 5'(i)));
    total++; if (count !== 4'd8) begin bad++; $display("FAIL full_count: got %0d expected 8", count); end
    total++; if (disp_ready !== 1'b0) begin bad++; $display("FAIL full_disp_ready: got %0b expected 0", disp_ready); end
    total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL full_none_ready: got %0b expected 0", issue_valid); end
    disp_valid = 1'b1; disp_uop = mk(uopc::UOP_OR, 6'd1, 1'b0, 6'd2, 1'b0, 5'd30);
    wb_valid = 2'b01; wb_ptag[0] = 6'd13; #1;
    tick();
    total++; if (count !== 4'd8) begin bad++; $display("FAIL full_no_overflow: got %0d expected 8", count); end
    total++; if (issue_valid !== 1'b1 || issue_uop.rob_idx !== 5'd3) begin bad++; $display("FAIL full_wake3: got rob %0d expected 3", issue_uop.rob_idx); end
    issue_ready = 1'b1; disp_valid = 1'b1; disp_uop = mk(uopc::UOP_OR, 6'd1, 1'b0, 6'd2, 1'b0, 5'd31); #1;
    total++; if (disp_ready !== 1'b0) begin bad++; $display("FAIL full_issue_no_slot: got %0b expected 0", disp_ready); end
    tick();
    total++; if (count !== 4'd7) begin bad++; $display("FAIL full_after_issue: got %0d expected 7", count); end
    for (int j = 0; j < 4; j++) begin
      wb_valid = 2'b11; wb_ptag[0] = 6'(tags[2*j]); wb_ptag[1] = 6'(tags[2*j+1]); #1;
      tick();
    end
    for (int j = 0; j < 7; j++) begin
      total++; if (issue_valid !== 1'b1 || issue_uop.rob_idx !== 5'(exp_rob[j])) begin bad++; $display("FAIL full_collapse_order[%0d]: got rob %0d expected %0d", j, issue_uop.rob_idx, exp_rob[j]); end
      issue_ready = 1'b1; tick();
    end
    total++; if (count !== 4'd0) begin bad++; $display("FAIL full_drain: got %0d expected 0", count); end
  endtask

  task automatic test_disp_and_issue();
    for (int i = 0; i < 4; i++) dispatch(mk(uopc::UOP_ORI, 6'd1, 1'b0, 6'd0, 1'b0, 5'(20 + i)));
    disp_valid = 1'b1; disp_uop = mk(uopc::UOP_ANDI, 6'd2, 1'b0, 6'd0, 1'b0, 5'd24);
    issue_ready = 1'b1; #1;
    total++; if (issue_uop.rob_idx !== 5'd20 || disp_ready !== 1'b1) begin bad++; $display("FAIL dui_head: got rob %0d ready %0b expected 20 1", issue_uop.rob_idx, disp_ready); end
    tick();
    total++; if (count !== 4'd4) begin bad++; $display("FAIL dui_count: got %0d expected 4", count); end
    for (int j = 0; j < 4; j++) begin
      total++; if (issue_valid !== 1'b1 || issue_uop.rob_idx !== 5'(21 + j)) begin bad++; $display("FAIL dui_order[%0d]: got rob %0d expected %0d", j, issue_uop.rob_idx, 21 + j); end
      issue_ready = 1'b1; tick();
    end
  endtask

  task automatic test_bypass();
    disp_valid = 1'b1; disp_uop = mk(uopc::UOP_XOR, 6'd0, 1'b1, 6'd9, 1'b1, 5'd12);
    wb_valid = 2'b10; wb_ptag[1] = 6'd9; #1;
    tick();
    total++; if (issue_valid !== 1'b1 || issue_uop.rob_idx !== 5'd12) begin bad++; $display("FAIL bypass_ready: got valid %0b rob %0d expected 1 12", issue_valid, issue_uop.rob_idx); end
    dispatch(mk(uopc::UOP_AND, 6'd9, 1'b1, 6'd0, 1'b0, 5'd13));
    issue_ready = 1'b1; tick();
    total++; if (issue_valid !== 1'b0 || count !== 4'd1) begin bad++; $display("FAIL bypass_busy_held: got valid %0b count %0d expected 0 1", issue_valid, count); end
    wb_valid = 2'b01; wb_ptag[0] = 6'd9; #1;
    tick();
    total++; if (issue_valid !== 1'b1 || issue_uop.rob_idx !== 5'd13) begin bad++; $display("FAIL bypass_late_wake: got valid %0b rob %0d expected 1 13", issue_valid, issue_uop.rob_idx); end
    issue_ready = 1'b1; tick();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) dispatch(mk(uopc::UOP_SLT, 6'd3, 1'(i % 2), 6'd4, 1'b0, 5'(i)));
    total++; if (count !== 4'd5) begin bad++; $display("FAIL flush_pre_count: got %0d expected 5", count); end
    flush = 1'b1; disp_valid = 1'b1; disp_uop = mk(uopc::UOP_SLL, 6'd1, 1'b0, 6'd1, 1'b0, 5'd9);
    issue_ready = 1'b1; #1;
    total++; if (issue_valid !== 1'b0 || disp_ready !== 1'b0) begin bad++; $display("FAIL flush_handshakes: got iv %0b dr %0b expected 0 0", issue_valid, disp_ready); end
    tick();
    total++; if (count !== 4'd0) begin bad++; $display("FAIL flush_count: got %0d expected 0", count); end
    total++; if (disp_ready !== 1'b1 || issue_valid !== 1'b0) begin bad++; $display("FAIL flush_after: got dr %0b iv %0b expected 1 0", disp_ready, issue_valid); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) dispatch(mk(uopc::UOP_SRA, 6'd2, 1'b0, 6'd3, 1'b0, 5'(i)));
    rst = 1'b1; #1;
    total++; if (issue_valid !== 1'b0 || disp_ready !== 1'b0) begin bad++; $display("FAIL rstmid_outputs: got iv %0b dr %0b expected 0 0", issue_valid, disp_ready); end
    tick();
    rst = 1'b0; #1;
    total++; if (count !== 4'd0 || issue_valid !== 1'b0 || disp_ready !== 1'b1) begin bad++; $display("FAIL rstmid_after: got cnt %0d iv %0b dr %0b expected 0 0 1", count, issue_valid, disp_ready); end
  endtask

  task automatic test_random();
    int k;
    iq_entry_t u;
    for (int c = 0; c < 600; c++) begin
      u.uopcode    = uopc::micro_opcode_t'(5'($urandom_range(1, 21)));
      u.packed_imm = 20'($urandom);
      u.imm_type   = immt::imm_type_t'(3'($urandom_range(0, 5)));
      u.prs1       = 6'($urandom_range(0, 7));
      u.prs2       = 6'($urandom_range(0, 7));
      u.prs1_busy  = 1'($urandom_range(0, 1));
      u.prs2_busy  = 1'($urandom_range(0, 1));
      u.pdst       = 6'($urandom);
      u.rob_idx    = 5'($urandom);
      disp_uop    = u;
      disp_valid  = ($urandom_range(0, 3) != 0);
      issue_ready = ($urandom_range(0, 2) != 0);
      wb_valid    = 2'($urandom_range(0, 3));
      wb_ptag[0]  = 6'($urandom_range(0, 7));
      wb_ptag[1]  = 6'($urandom_range(0, 7));
      flush       = ($urandom_range(0, 49) == 0);
      rst         = ($urandom_range(0, 99) == 0);
      #1;
      k = model_sel();
      total++; if (count !== 4'(mq.size())) begin bad++; $display("FAIL rand_count c=%0d: got %0d expected %0d", c, count, mq.size()); end
      total++; if (disp_ready !== (!rst && !flush && mq.size() < 8)) begin bad++; $display("FAIL rand_disp_ready c=%0d: got %0b expected %0b", c, disp_ready, (!rst && !flush && mq.size() < 8)); end
      total++; if (issue_valid !== (k >= 0 && !rst && !flush)) begin bad++; $display("FAIL rand_issue_valid c=%0d: got %0b expected %0b", c, issue_valid, (k >= 0 && !rst && !flush)); end
      if (k >= 0) begin
        total++; if (issue_uop !== mq[k]) begin bad++; $display("FAIL rand_issue_uop c=%0d: got %h expected %h", c, issue_uop, mq[k]); end
      end
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_addi();
    test_wakeup_order();
    test_full();
    test_disp_and_issue();
    test_bypass();
    test_flush();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_issue_queue.md
ALU_ISSUE_QUEUE -- requirements
Module: alu_issue_queue

Interface
- REQ-001 Parameter DEPTH, default 8: number of queue entries.
- REQ-002 Parameter PREG_W, default 6: physical register tag width.
- REQ-003 Parameter ROB_W, default 5: ROB index width.
- REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
- REQ-005 rst  input  1  synchronous, active-high reset.
- REQ-006 flush  input  1  squash all entries.
- REQ-007 disp_valid  input  1  dispatch request.
- REQ-008 disp_ready  output  1  queue can accept a dispatch this cycle.
- REQ-009 disp_uop  input  iq_entry_t  uopcode, packed_imm[19:0], imm_type, prs1, prs2, prs1_busy, prs2_busy, pdst, rob_idx.
- REQ-010 wb_valid  input  2  wakeup broadcast valid, one bit per port.
- REQ-011 wb_ptag  input  2xPREG_W  wakeup tags.
- REQ-012 issue_valid  output  1  a ready uop is presented.
- REQ-013 issue_ready  input  1  register-read stage accepts the uop.
- REQ-014 issue_uop  output  iq_entry_t  selected entry, busy bits zero.
- REQ-015 count  output  $clog2(DEPTH+1)  occupied entries.

Function
- REQ-016 Collapsing queue: occupied entries occupy indices 0..count-1 contiguously; index 0 is the oldest.
- REQ-017 disp_ready = !rst && !flush && (count < DEPTH); issuing in the same cycle does not free a slot for a dispatch while full.
- REQ-018 A dispatch fires when disp_valid && disp_ready; the entry is written at index count, or at count-1 if an issue also fires that cycle.
- REQ-019 Wakeup: for each port p with wb_valid[p], clear prsX_busy in every valid entry whose prsX == wb_ptag[p]; this also applies to entries being shifted that cycle.
- REQ-020 Dispatch bypass: an incoming busy bit is stored as 0 if its tag matches a same-cycle valid wakeup.
- REQ-021 A tag of 0 (x0) is never stored busy.
- REQ-022 An entry is ready when valid and both busy bits are 0; wakeup-to-issue latency is exactly 1 cycle (select reads registered state).
- REQ-023 Select: issue_uop is the lowest-index ready entry; issue_valid = any entry ready && !flush; purely combinational from registered state.
- REQ-024 Issue fires when issue_valid && issue_ready; the selected entry k is removed, and entries k+1..count-1 shift to k..count-2 at the next edge.
- REQ-025 While issue_valid && !issue_ready, issue_uop holds unless an older entry becomes ready (oldest-first preempts).
- REQ-026 Count update: +1 on dispatch only, -1 on issue only, unchanged on both or neither; it never exceeds DEPTH or underflows.
- REQ-027 Flush: at the next edge all valid bits clear and count = 0; a same-cycle dispatch or issue is discarded; wakeups are ignored.
- REQ-028 Payload fields are carried unmodified; no decode is performed inside the block.

Reset
- REQ-029 On rst at a clock edge: all valid bits 0, count 0; issue_valid 0 and disp_ready 0 while rst is high.
- REQ-030 The first cycle after rst deasserts: disp_ready 1, issue_valid 0.
- REQ-031 Reset mid-operation discards all entries identically to flush; payload registers need no reset.

Structure
- REQ-032 iq_entry_t and the wakeup port count (2) belong in the shared rv32i_types package; it uses uopc::micro_opcode_t and immt::imm_type_t.
- REQ-033 One sub-module, iq_select: DEPTH-bit ready vector -> one-hot grant plus index, lowest index wins.

Verification
- REQ-034 Dispatch addi with both tags not busy on an empty queue -> issue_valid next cycle, issue_uop.uopcode = addi, count 1 -> 0 after issue.
- REQ-035 Dispatch add (prs1 = 5, busy), then sub (ready); issue_ready = 1 -> sub issues first; wb_ptag[0] = 5 -> add issues the following cycle.
- REQ-036 Fill 8 entries, all busy -> disp_ready = 0, count = 8; wake entry 3 -> it issues, and entries 4..7 appear at 3..6.
- REQ-037 Queue at count 4, dispatch and issue of index 0 in the same cycle -> count stays 4, the new entry is at index 3, order is preserved.
- REQ-038 Dispatch with prs2 = 9 busy while wb_ptag[1] = 9 is valid in the same cycle -> entry stored ready, issues next cycle.
- REQ-039 Queue with 5 entries; assert flush together with dispatch and issue_ready -> count = 0 next cycle, no issue handshake, disp_ready = 1.
